// File: rtl/record_read_scheduler_pkg.sv
// Shared types for the record storage read path: the PlayRecord layout,
// read-scheduler state/owner encodings and the history cache size.
package record_read_scheduler_pkg;

    localparam int HIST_SLOTS = 9;

    typedef struct packed {
        logic [7:0]  rec_id;
        logic [15:0] score;
        logic [7:0]  level;
    } PlayRecord;

    typedef enum logic {
        OWN_SWEEP,
        OWN_CLIENT
    } RdOwner;

    typedef enum logic [1:0] {
        RS_IDLE,
        RS_WAIT,
        RS_CAPTURE
    } RdSchedState;

    // Record ids 1..num_slots map onto cache slots; id 0 is never cached.
    function automatic logic id_in_cache(input logic [7:0] id, input int num_slots);
        return (id != 8'd0) && (int'(id) <= num_slots);
    endfunction

endpackage

// File: rtl/record_read_scheduler_cache.sv
// NUM_SLOTS-entry PlayRecord register file indexed by record id (1-based),
// with one write port, per-slot fill flags and a combinational read port.
module record_read_scheduler_cache
    import record_read_scheduler_pkg::*;
#(
    parameter int NUM_SLOTS = HIST_SLOTS
) (
    input  logic                 prog_clk,
    input  logic                 rst,
    input  logic                 i_wr_en,
    input  logic [7:0]           i_wr_id,
    input  PlayRecord            i_wr_data,
    input  logic [7:0]           i_rd_id,
    output PlayRecord            o_rd_data,
    output logic [NUM_SLOTS-1:0] o_valid
);

    localparam int AW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    PlayRecord            r_mem [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] r_valid;
    logic [AW-1:0]        w_wr_idx;
    logic [AW-1:0]        w_rd_idx;

    assign w_wr_idx = AW'(i_wr_id - 8'd1);
    assign w_rd_idx = AW'(i_rd_id - 8'd1);
    assign o_valid  = r_valid;

    always_ff @(posedge prog_clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_SLOTS; k++) begin
                r_mem[k] <= '0;
            end
            r_valid <= '0;
        end else if (i_wr_en && id_in_cache(i_wr_id, NUM_SLOTS)) begin
            r_mem[w_wr_idx]   <= i_wr_data;
            r_valid[w_wr_idx] <= 1'b1;
        end
    end

    always_comb begin
        o_rd_data = '0;
        if (id_in_cache(i_rd_id, NUM_SLOTS)) begin
            o_rd_data = r_mem[w_rd_idx];
        end
    end

endmodule

// File: rtl/record_read_scheduler.sv
// Time-shares the single RecordStorageManager read port between a background
// sweep that keeps the history cache fresh and one on-demand client.
module record_read_scheduler
    import record_read_scheduler_pkg::*;
#(
    parameter int NUM_SLOTS      = HIST_SLOTS,
    parameter int READ_LAT       = 1,
    parameter int REFRESH_CYCLES = 30
) (
    input  logic                 prog_clk,
    input  logic                 rst,
    output logic [7:0]           rec_read_id,
    input  PlayRecord            rec_read_data,
    input  logic                 req_valid,
    input  logic [7:0]           req_id,
    output logic                 req_ready,
    output logic                 resp_valid,
    output PlayRecord            resp_data,
    input  logic                 invalidate,
    input  logic [7:0]           disp_id,
    output PlayRecord            disp_rec,
    output logic [NUM_SLOTS-1:0] cache_valid,
    output logic                 sweep_done
);

    localparam int             LW       = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam int             RW       = (REFRESH_CYCLES > 0) ? $clog2(REFRESH_CYCLES + 1) : 1;
    localparam logic [LW-1:0]  LAT_INIT = LW'(READ_LAT - 1);
    localparam logic [RW-1:0]  REF_INIT = RW'(REFRESH_CYCLES);
    localparam logic [7:0]     LAST_ID  = 8'(NUM_SLOTS);

    RdSchedState   r_state;
    RdOwner        r_owner;
    logic [LW-1:0] r_lat_cnt;
    logic [7:0]    r_rec_read_id;
    logic [7:0]    r_sweep_slot;
    logic          r_sweep_pending;
    logic [RW-1:0] r_refresh_cnt;
    logic          r_restart;
    logic          r_client_last;
    logic          r_resp_valid;
    PlayRecord     r_resp_data;
    logic          r_sweep_done;

    logic          w_restart;
    logic [7:0]    w_slot;
    logic          w_pend;
    logic [RW-1:0] w_refresh;
    logic          w_done;
    logic          w_ready;
    logic          w_grant_client;
    logic          w_grant_sweep;
    logic          w_cache_wr;

    // CAPTURE doubles as a return-to-idle slot: sweep bookkeeping settles and a
    // new grant can issue on the same edge, giving one read per READ_LAT+1 cycles.
    always_comb begin
        w_restart = (r_state != RS_WAIT) && (r_restart || invalidate);
        w_slot    = r_sweep_slot;
        w_pend    = r_sweep_pending;
        w_refresh = r_refresh_cnt;
        w_done    = 1'b0;
        if (r_state == RS_CAPTURE && r_owner == OWN_SWEEP) begin
            if (r_rec_read_id == LAST_ID) begin
                w_slot    = 8'd1;
                w_pend    = (REFRESH_CYCLES == 0);
                w_refresh = REF_INIT;
                w_done    = 1'b1;
            end else begin
                w_slot = r_rec_read_id + 8'd1;
            end
        end else if (r_state == RS_IDLE && r_refresh_cnt != '0) begin
            w_refresh = r_refresh_cnt - RW'(1);
            if (r_refresh_cnt == RW'(1)) begin
                w_pend = 1'b1;
            end
        end
        if (w_restart) begin
            w_slot    = 8'd1;
            w_pend    = 1'b1;
            w_refresh = '0;
            w_done    = 1'b0;
        end
        // After serving the client, a pending sweep gets the next slot.
        w_ready        = (r_state != RS_WAIT) && !(w_pend && r_client_last);
        w_grant_client = req_valid && w_ready;
        w_grant_sweep  = (r_state != RS_WAIT) && w_pend && !w_grant_client;
    end

    assign w_cache_wr = (r_state == RS_WAIT) && (r_lat_cnt == '0);

    always_ff @(posedge prog_clk or posedge rst) begin
        if (rst) begin
            r_state         <= RS_IDLE;
            r_owner         <= OWN_SWEEP;
            r_lat_cnt       <= '0;
            r_rec_read_id   <= 8'd0;
            r_sweep_slot    <= 8'd1;
            r_sweep_pending <= 1'b1;
            r_refresh_cnt   <= '0;
            r_restart       <= 1'b0;
            r_client_last   <= 1'b0;
            r_resp_valid    <= 1'b0;
            r_resp_data     <= '0;
            r_sweep_done    <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;
            r_sweep_done <= 1'b0;
            case (r_state)
                RS_WAIT: begin
                    if (invalidate) begin
                        r_restart <= 1'b1;
                    end
                    if (r_lat_cnt != '0) begin
                        r_lat_cnt <= r_lat_cnt - LW'(1);
                    end else begin
                        r_state <= RS_CAPTURE;
                        if (r_owner == OWN_CLIENT) begin
                            r_resp_valid <= 1'b1;
                            r_resp_data  <= rec_read_data;
                        end
                    end
                end
                default: begin
                    r_sweep_slot    <= w_slot;
                    r_sweep_pending <= w_pend;
                    r_refresh_cnt   <= w_refresh;
                    r_sweep_done    <= w_done;
                    r_restart       <= 1'b0;
                    if (w_grant_client) begin
                        r_rec_read_id <= req_id;
                        r_owner       <= OWN_CLIENT;
                        r_client_last <= 1'b1;
                        r_lat_cnt     <= LAT_INIT;
                        r_state       <= RS_WAIT;
                    end else if (w_grant_sweep) begin
                        r_rec_read_id <= w_slot;
                        r_owner       <= OWN_SWEEP;
                        r_client_last <= 1'b0;
                        r_lat_cnt     <= LAT_INIT;
                        r_state       <= RS_WAIT;
                    end else begin
                        r_state <= RS_IDLE;
                    end
                end
            endcase
        end
    end

    record_read_scheduler_cache #(
        .NUM_SLOTS (NUM_SLOTS)
    ) u_cache (
        .prog_clk  (prog_clk),
        .rst       (rst),
        .i_wr_en   (w_cache_wr),
        .i_wr_id   (r_rec_read_id),
        .i_wr_data (rec_read_data),
        .i_rd_id   (disp_id),
        .o_rd_data (disp_rec),
        .o_valid   (cache_valid)
    );

    assign rec_read_id = r_rec_read_id;
    assign req_ready   = w_ready;
    assign resp_valid  = r_resp_valid;
    assign resp_data   = r_resp_data;
    assign sweep_done  = r_sweep_done;

endmodule

// File: tb/tb_record_read_scheduler.sv
// Directed bench for record_read_scheduler with a combinational storage model
// returning score = 10*id + bias.
module tb_record_read_scheduler;
    import record_read_scheduler_pkg::*;

    logic       prog_clk;
    logic       rst;
    logic [7:0] rec_read_id;
    PlayRecord  rec_read_data;
    logic       req_valid;
    logic [7:0] req_id;
    logic       req_ready;
    logic       resp_valid;
    PlayRecord  resp_data;
    logic       invalidate;
    logic [7:0] disp_id;
    PlayRecord  disp_rec;
    logic [8:0] cache_valid;
    logic       sweep_done;

    logic [15:0] bias;
    int n_cmp = 0;
    int n_bad = 0;

    record_read_scheduler #(
        .NUM_SLOTS      (9),
        .READ_LAT       (1),
        .REFRESH_CYCLES (30)
    ) dut (
        .prog_clk      (prog_clk),
        .rst           (rst),
        .rec_read_id   (rec_read_id),
        .rec_read_data (rec_read_data),
        .req_valid     (req_valid),
        .req_id        (req_id),
        .req_ready     (req_ready),
        .resp_valid    (resp_valid),
        .resp_data     (resp_data),
        .invalidate    (invalidate),
        .disp_id       (disp_id),
        .disp_rec      (disp_rec),
        .cache_valid   (cache_valid),
        .sweep_done    (sweep_done)
    );

    initial prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    always_comb begin
        rec_read_data.rec_id = rec_read_id;
        rec_read_data.score  = 16'(rec_read_id) * 16'd10 + bias;
        rec_read_data.level  = 8'hA5;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    typedef struct {
        logic [7:0]  id;
        logic [15:0] resp_score;
        logic [7:0]  probe;
        logic [15:0] probe_score;
    } vec_t;

    typedef struct {
        logic [7:0]  id;
        logic [15:0] score;
    } disp_t;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  vt [6];
        disp_t dt [5];
        int    done_cnt;
        int    done_at;
        logic [31:0] exp_id;

        vt[0] = '{8'd0,   16'd3000, 8'd2,  16'd1020};
        vt[1] = '{8'd12,  16'd3120, 8'd12, 16'd0};
        vt[2] = '{8'd7,   16'd3070, 8'd7,  16'd3070};
        vt[3] = '{8'd255, 16'd5550, 8'd8,  16'd1080};
        vt[4] = '{8'd1,   16'd3010, 8'd1,  16'd3010};
        vt[5] = '{8'd9,   16'd3090, 8'd9,  16'd3090};
        dt[0] = '{8'd4,  16'd40};
        dt[1] = '{8'd1,  16'd10};
        dt[2] = '{8'd9,  16'd90};
        dt[3] = '{8'd0,  16'd0};
        dt[4] = '{8'd10, 16'd0};

        rst = 1'b1; req_valid = 1'b0; req_id = 8'd0; invalidate = 1'b0;
        disp_id = 8'd1; bias = 16'd0;
        repeat (3) tick();

        // Reset state
        chk("rst_id", 32'(rec_read_id), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_cache_valid", 32'(cache_valid), 32'd0);
        chk("rst_sweep_done", 32'(sweep_done), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_disp", 32'(disp_rec.score), 32'd0);

        // First sweep after release: one id every 2 cycles, done on edge 19
        @(negedge prog_clk);
        rst = 1'b0;
        done_cnt = 0; done_at = 0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if ((c % 2 == 1) && (c <= 17)) chk("sweep_id", 32'(rec_read_id), 32'((c + 1) / 2));
            if (sweep_done) begin
                done_cnt++;
                if (done_at == 0) done_at = c;
            end
        end
        chk("sweep_done_count", 32'(done_cnt), 32'd1);
        chk("sweep_done_edge", 32'(done_at), 32'd19);
        chk("cache_valid_full", 32'(cache_valid), 32'h1FF);
        foreach (dt[i]) begin
            disp_id = dt[i].id;
            #1;
            chk("disp_score", 32'(disp_rec.score), 32'(dt[i].score));
        end

        // Invalidate during slot 5 WAIT restarts the sweep at id 1
        bias = 16'd1000;
        invalidate = 1'b1;
        tick();
        invalidate = 1'b0;
        chk("inv_start_id", 32'(rec_read_id), 32'd1);
        done_cnt = 0; done_at = 0;
        for (int t = 1; t <= 30; t++) begin
            tick();
            if (t == 9) invalidate = 1'b0;
            if (t == 8) begin
                chk("inv_slot5_id", 32'(rec_read_id), 32'd5);
                invalidate = 1'b1;
            end
            if (t == 9) begin
                disp_id = 8'd5;
                #1;
                chk("inv_slot5_written", 32'(disp_rec.score), 32'd1050);
            end
            if (t == 10) chk("inv_restart_id", 32'(rec_read_id), 32'd1);
            if (sweep_done) begin
                done_cnt++;
                if (done_at == 0) done_at = t;
            end
        end
        chk("inv_done_count", 32'(done_cnt), 32'd1);
        chk("inv_done_edge", 32'(done_at), 32'd28);
        chk("inv_cache_valid", 32'(cache_valid), 32'h1FF);

        // Continuous client demand alternates with a pending sweep
        invalidate = 1'b1; req_valid = 1'b1; req_id = 8'd200;
        tick();
        invalidate = 1'b0;
        for (int j = 0; j <= 18; j++) begin
            exp_id = (j % 2 == 0) ? 32'd200 : 32'((j + 1) / 2);
            chk("alt_id", 32'(rec_read_id), exp_id);
            if (j == 17) chk("alt_no_done", 32'(sweep_done), 32'd0);
            if (j == 18) chk("alt_done", 32'(sweep_done), 32'd1);
            tick();
            if (j % 2 == 0) begin
                chk("alt_resp_valid", 32'(resp_valid), 32'd1);
                chk("alt_resp_score", 32'(resp_data.score), 32'd3000);
            end
            if (j == 18) req_valid = 1'b0;
            if (j < 18) tick();
        end
        tick();

        // Table-driven client reads, in and out of the cached id range
        bias = 16'd3000;
        foreach (vt[i]) begin
            chk("tbl_ready", 32'(req_ready), 32'd1);
            req_valid = 1'b1; req_id = vt[i].id;
            tick();
            req_valid = 1'b0;
            chk("tbl_id", 32'(rec_read_id), 32'(vt[i].id));
            chk("tbl_resp_early", 32'(resp_valid), 32'd0);
            tick();
            chk("tbl_resp_valid", 32'(resp_valid), 32'd1);
            chk("tbl_resp_score", 32'(resp_data.score), 32'(vt[i].resp_score));
            chk("tbl_resp_recid", 32'(resp_data.rec_id), 32'(vt[i].id));
            tick();
            chk("tbl_resp_drop", 32'(resp_valid), 32'd0);
            chk("tbl_resp_hold", 32'(resp_data.score), 32'(vt[i].resp_score));
            disp_id = vt[i].probe;
            #1;
            chk("tbl_disp", 32'(disp_rec.score), 32'(vt[i].probe_score));
            chk("tbl_cache_valid", 32'(cache_valid), 32'h1FF);
        end

        // Client raised in a sweep WAIT waits for the following idle edge
        bias = 16'd0;
        invalidate = 1'b1;
        tick();
        invalidate = 1'b0;
        chk("mid_sweep_id", 32'(rec_read_id), 32'd1);
        req_valid = 1'b1; req_id = 8'd7;
        chk("mid_ready_wait", 32'(req_ready), 32'd0);
        tick();
        chk("mid_ready_capture", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        chk("mid_client_id", 32'(rec_read_id), 32'd7);
        chk("mid_resp_e0", 32'(resp_valid), 32'd0);
        tick();
        chk("mid_resp_e1", 32'(resp_valid), 32'd1);
        chk("mid_resp_score", 32'(resp_data.score), 32'd70);
        tick();
        chk("mid_resp_e2", 32'(resp_valid), 32'd0);
        chk("mid_next_sweep_id", 32'(rec_read_id), 32'd2);
        disp_id = 8'd7;
        #1;
        chk("mid_cache_coherent", 32'(disp_rec.score), 32'd70);
        done_cnt = 0; done_at = 0;
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (sweep_done) begin
                done_cnt++;
                if (done_at == 0) done_at = t;
            end
        end
        chk("mid_done_count", 32'(done_cnt), 32'd1);
        chk("mid_done_edge", 32'(done_at), 32'd16);

        // Asynchronous reset during a client WAIT
        req_valid = 1'b1; req_id = 8'd3;
        tick();
        req_valid = 1'b0;
        chk("rr_client_id", 32'(rec_read_id), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("rr_id_async", 32'(rec_read_id), 32'd0);
        chk("rr_cache_valid_async", 32'(cache_valid), 32'd0);
        chk("rr_disp_async", 32'(disp_rec.score), 32'd0);
        chk("rr_resp_async", 32'(resp_valid), 32'd0);
        tick();
        tick();
        chk("rr_resp_held", 32'(resp_valid), 32'd0);
        @(negedge prog_clk);
        rst = 1'b0;
        tick();
        chk("rr_restart_id", 32'(rec_read_id), 32'd1);
        chk("rr_no_resp", 32'(resp_valid), 32'd0);
        tick();
        chk("rr_no_resp_capture", 32'(resp_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
